stall_gen_multi: RTL and testbench

Multi-channel, parametrised successor to the single-channel core stall generator. Each channel owns an independent down-counter and three-state FSM that produces one-shot or periodic stall windows of programmable length. Per-channel stalls are ORed into a single core stall. Per-channel done pulses and busy flags let the core or test logic track completion. The block sits beside the pipeline control logic and drives the global stall request used for memory and peripheral latency emulation.

---
 rtl/stall_gen_multi.sv | 131 +++++++++++++
 tb/tb_stall_gen_multi.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_gen_multi.sv
// Multi-channel stall generator. Each channel runs its own IDLE/STALL/GAP FSM with a down-counter.
// The channel stalls are ORed into one core stall request.
module stall_gen_multi #(
    parameter int NUM_CH      = 4,
    parameter int COUNT_W     = 13,
    parameter int SCALE_SHIFT = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_CH-1:0]           i_start,
    input  logic [NUM_CH-1:0]           i_stop,
    input  logic [NUM_CH-1:0]           i_periodic,
    input  logic [NUM_CH*COUNT_W-1:0]   i_count,
    input  logic [NUM_CH*COUNT_W-1:0]   i_gap,
    output logic                        o_stall,
    output logic [NUM_CH-1:0]           o_ch_stall,
    output logic [NUM_CH-1:0]           o_busy,
    output logic [NUM_CH-1:0]           o_done
);

    // One extra bit over COUNT_W+SCALE_SHIFT holds (count+1)<<SCALE_SHIFT without overflow.
    localparam int CNT_W = COUNT_W + SCALE_SHIFT + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            state_t             r_state;
            state_t             w_state_nxt;
            logic [CNT_W-1:0]   r_cnt;
            logic [CNT_W-1:0]   w_cnt_nxt;
            logic [CNT_W-1:0]   r_len;
            logic [CNT_W-1:0]   w_len_nxt;
            logic [CNT_W-1:0]   w_len_in;
            logic [COUNT_W-1:0] r_gap;
            logic [COUNT_W-1:0] w_gap_nxt;
            logic               r_per;
            logic               w_per_nxt;
            logic               r_done;
            logic               w_done_nxt;
            logic               w_cnt_one;

            assign w_len_in  = (CNT_W'(i_count[k*COUNT_W +: COUNT_W]) + CNT_W'(1)) << SCALE_SHIFT;
            assign w_cnt_one = (r_cnt == CNT_W'(1));

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_len   <= '0;
                    r_gap   <= '0;
                    r_per   <= 1'b0;
                    r_done  <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_len   <= w_len_nxt;
                    r_gap   <= w_gap_nxt;
                    r_per   <= w_per_nxt;
                    r_done  <= w_done_nxt;
                end
            end

            // Stop beats start, start beats the running count; a retrigger never reports done.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_len_nxt   = r_len;
                w_gap_nxt   = r_gap;
                w_per_nxt   = r_per;
                w_done_nxt  = 1'b0;
                if (i_stop[k]) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (i_start[k]) begin
                    w_state_nxt = ST_STALL;
                    w_cnt_nxt   = w_len_in;
                    w_len_nxt   = w_len_in;
                    w_gap_nxt   = i_gap[k*COUNT_W +: COUNT_W];
                    w_per_nxt   = i_periodic[k];
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            w_cnt_nxt = '0;
                        end
                        ST_STALL: begin
                            if (w_cnt_one) begin
                                w_done_nxt = 1'b1;
                                if (!r_per) begin
                                    w_state_nxt = ST_IDLE;
                                    w_cnt_nxt   = '0;
                                end else if (r_gap != '0) begin
                                    w_state_nxt = ST_GAP;
                                    w_cnt_nxt   = CNT_W'(r_gap);
                                end else begin
                                    w_cnt_nxt   = r_len;
                                end
                            end else begin
                                w_cnt_nxt = r_cnt - CNT_W'(1);
                            end
                        end
                        ST_GAP: begin
                            if (w_cnt_one) begin
                                w_state_nxt = ST_STALL;
                                w_cnt_nxt   = r_len;
                            end else begin
                                w_cnt_nxt = r_cnt - CNT_W'(1);
                            end
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end
                    endcase
                end
            end

            assign o_ch_stall[k] = (r_state == ST_STALL);
            assign o_busy[k]     = (r_state != ST_IDLE);
            assign o_done[k]     = r_done;
        end
    endgenerate

    assign o_stall = |o_ch_stall;

endmodule

// File: tb/tb_stall_gen_multi.sv
// Scoreboard bench for stall_gen_multi: stimulus queues expected done pulses, a monitor checks them,
// plus directed checks of stall/busy shapes and two small parameter-sweep instances.
module tb_stall_gen_multi;

    localparam int NCH = 4;
    localparam int CW  = 13;

    typedef struct {
        int ch;
        int cyc;
        int stallAfter;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic [NCH-1:0]   iStart = '0;
    logic [NCH-1:0]   iStop = '0;
    logic [NCH-1:0]   iPeriodic = '0;
    logic [NCH*CW-1:0] iCount = '0;
    logic [NCH*CW-1:0] iGap = '0;
    logic             oStall;
    logic [NCH-1:0]   oChStall;
    logic [NCH-1:0]   oBusy;
    logic [NCH-1:0]   oDone;

    logic             sStart = 1'b0;
    logic [3:0]       s0Count = '0;
    logic [3:0]       s4Count = '0;
    logic             s0Stall, s0ChStall, s0Busy, s0Done;
    logic             s4Stall, s4ChStall, s4Busy, s4Done;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   monFound;
    exp_t sbQ[$];
    exp_t monExp;

    stall_gen_multi #(.NUM_CH(NCH), .COUNT_W(CW), .SCALE_SHIFT(1)) u_dut (
        .i_clk(clk), .i_rst_n(rstN), .i_start(iStart), .i_stop(iStop),
        .i_periodic(iPeriodic), .i_count(iCount), .i_gap(iGap),
        .o_stall(oStall), .o_ch_stall(oChStall), .o_busy(oBusy), .o_done(oDone)
    );

    stall_gen_multi #(.NUM_CH(1), .COUNT_W(4), .SCALE_SHIFT(0)) u_dut_s0 (
        .i_clk(clk), .i_rst_n(rstN), .i_start(sStart), .i_stop(1'b0),
        .i_periodic(1'b0), .i_count(s0Count), .i_gap(4'd0),
        .o_stall(s0Stall), .o_ch_stall(s0ChStall), .o_busy(s0Busy), .o_done(s0Done)
    );

    stall_gen_multi #(.NUM_CH(1), .COUNT_W(4), .SCALE_SHIFT(4)) u_dut_s4 (
        .i_clk(clk), .i_rst_n(rstN), .i_start(sStart), .i_stop(1'b0),
        .i_periodic(1'b0), .i_count(s4Count), .i_gap(4'd0),
        .o_stall(s4Stall), .o_ch_stall(s4ChStall), .o_busy(s4Busy), .o_done(s4Done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic setChannel(input int ch, input int count, input int gap, input logic per);
        iCount[ch*CW +: CW] = CW'(count);
        iGap[ch*CW +: CW]   = CW'(gap);
        iPeriodic[ch]       = per;
    endtask

    task automatic pushDone(input int ch, input int dcyc, input int stallAfter);
        exp_t e;
        e.ch = ch;
        e.cyc = dcyc;
        e.stallAfter = stallAfter;
        sbQ.push_back(e);
    endtask

    // Called at a falling edge; the pulse is sampled at the next rising edge (edge cyc+1).
    task automatic applyStimulus(input logic [NCH-1:0] startMask, input logic [NCH-1:0] stopMask);
        iStart = startMask;
        iStop  = stopMask;
        @(negedge clk);
        iStart = '0;
        iStop  = '0;
    endtask

    task automatic waitCyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation of its channel.
    always @(negedge clk) begin
        if (rstN) begin
            for (int k = 0; k < NCH; k++) begin
                if (oDone[k]) begin
                    monFound = -1;
                    for (int i = 0; i < sbQ.size(); i++) begin
                        if (monFound < 0 && sbQ[i].ch == k) monFound = i;
                    end
                    if (monFound < 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_done: channel %0d pulsed at cycle %0d, expected none", k, cyc);
                    end else begin
                        monExp = sbQ[monFound];
                        sbQ.delete(monFound);
                        checkOutput($sformatf("done_cycle_ch%0d", k), cyc, monExp.cyc);
                        checkOutput($sformatf("stall_at_done_ch%0d", k), int'(oChStall[k]), monExp.stallAfter);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, r, anyHigh, n0, n4, d0, d4;

        repeat (3) @(negedge clk);
        rstN = 1'b1;
        checkOutput("reset_stall", int'(oStall), 0);
        checkOutput("reset_ch_stall", int'(oChStall), 0);
        checkOutput("reset_busy", int'(oBusy), 0);
        checkOutput("reset_done", int'(oDone), 0);
        repeat (2) @(negedge clk);

        $display("[TB] one-shot, count=0 on ch0");
        setChannel(0, 0, 0, 1'b0);
        t = cyc + 1;
        pushDone(0, t + 2, 0);
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("oneshot_first_cycle", int'(oStall), 1);
        checkOutput("oneshot_busy", int'(oBusy), 1);
        waitCyc(t + 1);
        checkOutput("oneshot_second_cycle", int'(oStall), 1);
        waitCyc(t + 2);
        checkOutput("oneshot_fall", int'(oStall), 0);
        repeat (3) @(negedge clk);

        $display("[TB] one-shot, count=8191 on ch0");
        setChannel(0, 8191, 0, 1'b0);
        t = cyc + 1;
        pushDone(0, t + 16384, 0);
        applyStimulus(4'b0001, 4'b0000);
        waitCyc(t + 16383);
        checkOutput("max_len_last_stall", int'(oChStall[0]), 1);
        waitCyc(t + 16384);
        checkOutput("max_len_after", int'(oChStall[0]), 0);
        repeat (3) @(negedge clk);

        $display("[TB] periodic ch1 L=6 G=3 then stop in gap");
        setChannel(1, 2, 3, 1'b1);
        t = cyc + 1;
        pushDone(1, t + 6, 0);
        pushDone(1, t + 15, 0);
        pushDone(1, t + 24, 0);
        applyStimulus(4'b0010, 4'b0000);
        waitCyc(t + 9);
        checkOutput("periodic_restall", int'(oChStall[1]), 1);
        waitCyc(t + 24);
        checkOutput("periodic_gap_busy", int'(oBusy[1]), 1);
        checkOutput("periodic_gap_stall", int'(oChStall[1]), 0);
        waitCyc(t + 25);
        applyStimulus(4'b0000, 4'b0010);
        checkOutput("stop_busy", int'(oBusy[1]), 0);
        anyHigh = 0;
        repeat (20) begin
            @(negedge clk);
            if (oChStall[1]) anyHigh = 1;
        end
        checkOutput("stop_no_stall", anyHigh, 0);

        $display("[TB] retrigger ch2");
        setChannel(2, 4, 0, 1'b0);
        t = cyc + 1;
        applyStimulus(4'b0100, 4'b0000);
        waitCyc(t + 4);
        setChannel(2, 1, 0, 1'b0);
        r = cyc + 1;
        pushDone(2, r + 4, 0);
        applyStimulus(4'b0100, 4'b0000);
        waitCyc(r + 3);
        checkOutput("retrigger_last", int'(oChStall[2]), 1);
        waitCyc(r + 4);
        checkOutput("retrigger_end", int'(oChStall[2]), 0);
        repeat (10) @(negedge clk);

        $display("[TB] start and stop together on ch2");
        setChannel(2, 3, 0, 1'b0);
        applyStimulus(4'b0100, 4'b0100);
        checkOutput("start_stop_busy", int'(oBusy[2]), 0);
        repeat (3) @(negedge clk);
        checkOutput("start_stop_stall", int'(oChStall[2]), 0);

        $display("[TB] overlapping ch0 L=4 and ch3 L=10");
        setChannel(0, 1, 0, 1'b0);
        setChannel(3, 4, 0, 1'b0);
        t = cyc + 1;
        pushDone(0, t + 4, 0);
        pushDone(3, t + 12, 0);
        applyStimulus(4'b0001, 4'b0000);
        for (int c = 0; c < 14; c++) begin
            checkOutput($sformatf("overlap_or_c%0d", c), int'(oStall),
                        int'((c <= 3) || (c >= 2 && c <= 11)));
            iStart = (c == 1) ? 4'b1000 : 4'b0000;
            @(negedge clk);
        end
        iStart = '0;
        repeat (3) @(negedge clk);

        $display("[TB] simultaneous start on all channels");
        setChannel(0, 0, 0, 1'b0);
        setChannel(1, 1, 0, 1'b0);
        setChannel(2, 2, 0, 1'b0);
        setChannel(3, 3, 0, 1'b0);
        t = cyc + 1;
        pushDone(0, t + 2, 0);
        pushDone(1, t + 4, 0);
        pushDone(2, t + 6, 0);
        pushDone(3, t + 8, 0);
        applyStimulus(4'b1111, 4'b0000);
        checkOutput("all_start", int'(oChStall), 15);
        waitCyc(t + 3);
        checkOutput("all_t3", int'(oChStall), 14);
        waitCyc(t + 5);
        checkOutput("all_t5", int'(oChStall), 12);
        waitCyc(t + 10);

        $display("[TB] periodic G=0 on ch3");
        setChannel(3, 0, 0, 1'b1);
        t = cyc + 1;
        pushDone(3, t + 2, 1);
        pushDone(3, t + 4, 1);
        pushDone(3, t + 6, 1);
        applyStimulus(4'b1000, 4'b0000);
        waitCyc(t + 6);
        applyStimulus(4'b0000, 4'b1000);
        checkOutput("g0_stop", int'(oChStall[3]), 0);
        repeat (4) @(negedge clk);

        $display("[TB] reset mid periodic stall");
        setChannel(1, 2, 3, 1'b1);
        applyStimulus(4'b0010, 4'b0000);
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_stall", int'(oChStall[1]), 1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("async_reset_stall", int'(oStall), 0);
        checkOutput("async_reset_busy", int'(oBusy), 0);
        checkOutput("async_reset_done", int'(oDone), 0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        anyHigh = 0;
        repeat (12) begin
            @(negedge clk);
            if (oStall || (oBusy != '0) || (oDone != '0)) anyHigh = 1;
        end
        checkOutput("post_reset_quiet", anyHigh, 0);

        $display("[TB] parameter sweep instances");
        s0Count = 4'd15;
        s4Count = 4'd0;
        sStart  = 1'b1;
        @(negedge clk);
        sStart = 1'b0;
        n0 = 0; n4 = 0; d0 = 0; d4 = 0;
        for (int i = 0; i < 40; i++) begin
            if (s0Stall) n0++;
            if (s4Stall) n4++;
            if (s0Done) d0++;
            if (s4Done) d4++;
            @(negedge clk);
        end
        checkOutput("sweep_s0_len", n0, 16);
        checkOutput("sweep_s4_len", n4, 16);
        checkOutput("sweep_s0_done", d0, 1);
        checkOutput("sweep_s4_done", d4, 1);
        s4Count = 4'd15;
        sStart  = 1'b1;
        @(negedge clk);
        sStart = 1'b0;
        n4 = 0;
        for (int i = 0; i < 270; i++) begin
            if (s4Stall) n4++;
            @(negedge clk);
        end
        checkOutput("sweep_s4_max_len", n4, 256);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", sbQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
